// File: rtl/pbs_pkg.sv
// Shared types for the battle turn sequencer: state codes and attacker encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pbs_pkg;

    // Fixed codes: the display reads these straight off state_dbg.
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD      = 4'd1,
        WAIT_MOVE = 4'd2,
        P_ROLL    = 4'd3,
        P_APPLY   = 4'd4,
        P_CHECK   = 4'd5,
        P_HOLD    = 4'd6,
        AI_ROLL   = 4'd7,
        AI_APPLY  = 4'd8,
        AI_CHECK  = 4'd9,
        AI_HOLD   = 4'd10,
        WIN       = 4'd11,
        LOSE      = 4'd12
    } state_e;

    // Trainer select driven onto the datapath.
    localparam logic ACTR_PLAYER = 1'b0;
    localparam logic ACTR_AI     = 1'b1;

    // Width of the shared phase counter; holds SETTLE/HOLD lengths up to 255.
    localparam int PHASE_W = 8;

    // States in which the sequencer sits waiting on the user.
    function automatic logic is_quiet(input state_e s);
        return (s == IDLE) || (s == WAIT_MOVE) || (s == WIN) || (s == LOSE);
    endfunction

endpackage

// File: rtl/pbs_edge_det.sv
// One-bit rising-edge detector producing a single-cycle registered pulse.
// Latency: pulse is high the cycle after the first edge that samples d=1.
// Backpressure: none; a held level yields one pulse only.
// Ports: clk, rst (sync, active-low), d (level in), pulse (one-cycle out).
module pbs_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q;
    logic d_d;
    logic pulse_q;
    logic pulse_d;

    always_comb begin
        d_d     = d;
        pulse_d = d & ~d_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_q     <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            d_q     <= d_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/pbs_turn_ctrl.sv
// Battle turn sequencer: orders player roll/attack/check and AI roll/attack/check.
// Latency: reacts one cycle after a go/start level rises; all outputs registered (Moore).
// Backpressure: none; events arriving outside the states that accept them are dropped.
// Ports: clk, rst (sync active-low); start/go user levels; p_move_in move select;
//        ai_dead/p_dead from datapath HP; actr/stop/app_*_dmg/load_ai_hp datapath
//        controls; p_move, turn_cnt, win, lose, busy, state_dbg status.
module pbs_turn_ctrl
    import pbs_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int HOLD_CYCLES   = 16,
    parameter int TURN_W        = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              go,
    input  logic [1:0]        p_move_in,
    input  logic              ai_dead,
    input  logic              p_dead,
    output logic              actr,
    output logic              stop,
    output logic              app_ai_dmg,
    output logic              app_pl_dmg,
    output logic              load_ai_hp,
    output logic [1:0]        p_move,
    output logic [TURN_W-1:0] turn_cnt,
    output logic              win,
    output logic              lose,
    output logic              busy,
    output logic [3:0]        state_dbg
);

    localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HOLD_LAST   = PHASE_W'(HOLD_CYCLES - 1);
    localparam logic [TURN_W-1:0]  TURN_MAX    = {TURN_W{1'b1}};

    logic press_go;
    logic press_start;

    pbs_edge_det u_go_det (
        .clk   (clk),
        .rst   (rst),
        .d     (go),
        .pulse (press_go)
    );

    pbs_edge_det u_start_det (
        .clk   (clk),
        .rst   (rst),
        .d     (start),
        .pulse (press_start)
    );

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   cnt_q, cnt_d;
    logic [TURN_W-1:0]    turn_q, turn_d;
    logic [1:0]           p_move_q, p_move_d;
    logic                 actr_q, actr_d;
    logic                 stop_q, stop_d;
    logic                 app_ai_q, app_ai_d;
    logic                 app_pl_q, app_pl_d;
    logic                 load_q, load_d;
    logic                 win_q, win_d;
    logic                 lose_q, lose_d;
    logic                 busy_q, busy_d;

    // Next state, phase counter, turn counter and move latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        turn_d   = turn_q;
        p_move_d = p_move_q;

        case (state_q)
            IDLE:      if (press_start) state_d = LOAD;
            LOAD:      state_d = WAIT_MOVE;
            WAIT_MOVE: begin
                if (press_go) begin
                    p_move_d = p_move_in;
                    state_d  = P_ROLL;
                end
            end
            P_ROLL:    if (cnt_q == SETTLE_LAST) state_d = P_APPLY;
            P_APPLY:   state_d = P_CHECK;
            // HP was updated by the strobe of the previous cycle, so the
            // dead flag is valid here; only the defender's flag matters.
            P_CHECK:   state_d = ai_dead ? WIN : P_HOLD;
            P_HOLD:    if (cnt_q == HOLD_LAST) state_d = AI_ROLL;
            AI_ROLL:   if (cnt_q == SETTLE_LAST) state_d = AI_APPLY;
            AI_APPLY:  state_d = AI_CHECK;
            AI_CHECK:  state_d = p_dead ? LOSE : AI_HOLD;
            AI_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_MOVE;
                    if (turn_q != TURN_MAX) begin
                        turn_d = turn_q + 1'b1;
                    end
                end
            end
            WIN, LOSE: if (press_start) state_d = LOAD;
            default:   state_d = IDLE;
        endcase

        // The phase counter restarts on every state entry.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // New battle: turn count reads zero from the LOAD cycle onward.
        if (state_d == LOAD) begin
            turn_d = '0;
        end
    end

    // Moore outputs decoded from the next state so they change on state entry.
    always_comb begin
        actr_d   = ((state_d == AI_ROLL) || (state_d == AI_APPLY)) ? ACTR_AI : ACTR_PLAYER;
        stop_d   = !((state_d == P_ROLL) || (state_d == AI_ROLL));
        app_ai_d = (state_d == P_APPLY);
        app_pl_d = (state_d == AI_APPLY);
        load_d   = (state_d == LOAD);
        win_d    = (state_d == WIN);
        lose_d   = (state_d == LOSE);
        busy_d   = !is_quiet(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            turn_q   <= '0;
            p_move_q <= 2'b00;
            actr_q   <= ACTR_PLAYER;
            stop_q   <= 1'b1;
            app_ai_q <= 1'b0;
            app_pl_q <= 1'b0;
            load_q   <= 1'b0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            turn_q   <= turn_d;
            p_move_q <= p_move_d;
            actr_q   <= actr_d;
            stop_q   <= stop_d;
            app_ai_q <= app_ai_d;
            app_pl_q <= app_pl_d;
            load_q   <= load_d;
            win_q    <= win_d;
            lose_q   <= lose_d;
            busy_q   <= busy_d;
        end
    end

    assign actr       = actr_q;
    assign stop       = stop_q;
    assign app_ai_dmg = app_ai_q;
    assign app_pl_dmg = app_pl_q;
    assign load_ai_hp = load_q;
    assign p_move     = p_move_q;
    assign turn_cnt   = turn_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign busy       = busy_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
module tb_pbs_turn_ctrl;

    localparam int SETTLE = 8;
    localparam int HOLD   = 16;
    localparam int TW     = 6;
    localparam int TMAX   = (1 << TW) - 1;

    localparam int S_IDLE    = 0;
    localparam int S_LOAD    = 1;
    localparam int S_WAIT    = 2;
    localparam int S_PROLL   = 3;
    localparam int S_PAPPLY  = 4;
    localparam int S_PCHECK  = 5;
    localparam int S_PHOLD   = 6;
    localparam int S_AIROLL  = 7;
    localparam int S_AIAPPLY = 8;
    localparam int S_AICHECK = 9;
    localparam int S_AIHOLD  = 10;
    localparam int S_WIN     = 11;
    localparam int S_LOSE    = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          go;
    logic [1:0]    p_move_in;
    logic          ai_dead;
    logic          p_dead;
    logic          actr;
    logic          stop;
    logic          app_ai_dmg;
    logic          app_pl_dmg;
    logic          load_ai_hp;
    logic [1:0]    p_move;
    logic [TW-1:0] turn_cnt;
    logic          win;
    logic          lose;
    logic          busy;
    logic [3:0]    state_dbg;

    pbs_turn_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .HOLD_CYCLES   (HOLD),
        .TURN_W        (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .go         (go),
        .p_move_in  (p_move_in),
        .ai_dead    (ai_dead),
        .p_dead     (p_dead),
        .actr       (actr),
        .stop       (stop),
        .app_ai_dmg (app_ai_dmg),
        .app_pl_dmg (app_pl_dmg),
        .load_ai_hp (load_ai_hp),
        .p_move     (p_move),
        .turn_cnt   (turn_cnt),
        .win        (win),
        .lose       (lose),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: HP registers loaded at battle start and reduced by strobes.
    logic [7:0] ai_init = 8'd200;
    logic [7:0] pl_init = 8'd200;
    logic [7:0] dmg_ai  = 8'd0;
    logic [7:0] dmg_pl  = 8'd0;
    logic [7:0] ai_hp   = 8'd255;
    logic [7:0] pl_hp   = 8'd255;

    always @(posedge clk) begin
        if (!rst) begin
            ai_hp <= 8'd255;
            pl_hp <= 8'd255;
        end else begin
            if (load_ai_hp) begin
                ai_hp <= ai_init;
                pl_hp <= pl_init;
            end
            if (app_ai_dmg) ai_hp <= (ai_hp > dmg_ai) ? ai_hp - dmg_ai : 8'd0;
            if (app_pl_dmg) pl_hp <= (pl_hp > dmg_pl) ? pl_hp - dmg_pl : 8'd0;
        end
    end

    assign ai_dead = (ai_hp == 8'd0);
    assign p_dead  = (pl_hp == 8'd0);

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: expected per-cycle state schedule plus predicted HP/turn/move.
    int q[$];
    int exp_turn = 0;
    int exp_pm   = 0;
    int pred_ai  = 0;
    int pred_pl  = 0;
    int go_rel   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {state, actr, stop, app_ai, app_pl, load, win, lose, busy}
    function automatic logic [31:0] obs_vec();
        return 32'({state_dbg, actr, stop, app_ai_dmg, app_pl_dmg, load_ai_hp, win, lose, busy});
    endfunction

    // Output table straight from the state descriptions.
    function automatic logic [31:0] exp_vec(input int st);
        logic [3:0] code;
        code = 4'(st);
        return 32'({code,
                    (st == S_AIROLL) || (st == S_AIAPPLY),
                    !((st == S_PROLL) || (st == S_AIROLL)),
                    st == S_PAPPLY,
                    st == S_AIAPPLY,
                    st == S_LOAD,
                    st == S_WIN,
                    st == S_LOSE,
                    !((st == S_IDLE) || (st == S_WAIT) || (st == S_WIN) || (st == S_LOSE))});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int st, input int n);
        repeat (n) q.push_back(st);
    endtask

    // Walk the expected schedule one cycle per entry, then release inputs and
    // confirm the final state is sticky and the status counters are right.
    task automatic check_trace(input string tag);
        int last;
        for (int k = 0; k < q.size(); k++) begin
            tick();
            chk(tag, obs_vec(), exp_vec(q[k]));
            if (k + 1 == go_rel) go = 1'b0;
            if (k >= 1) p_move_in = 2'($urandom);
        end
        last  = q[q.size() - 1];
        go    = 1'b0;
        start = 1'b0;
        tick();
        chk({tag, "_settled"}, obs_vec(), exp_vec(last));
        chk("turn_cnt", 32'(turn_cnt), 32'(exp_turn));
        chk("p_move", 32'(p_move), 32'(exp_pm));
        q.delete();
    endtask

    task automatic do_start(input int from_state);
        push(from_state, 1);
        push(S_LOAD, 1);
        push(S_WAIT, 4);
        exp_turn = 0;
        pred_ai  = int'(ai_init);
        pred_pl  = int'(pl_init);
        go_rel   = 0;
        start    = 1'b1;
        check_trace("start");
    endtask

    task automatic do_round(input logic [1:0] pm, input int dai, input int dpl);
        dmg_ai = 8'(dai);
        dmg_pl = 8'(dpl);
        push(S_WAIT, 1);
        push(S_PROLL, SETTLE);
        push(S_PAPPLY, 1);
        push(S_PCHECK, 1);
        pred_ai = (pred_ai > dai) ? pred_ai - dai : 0;
        if (pred_ai == 0) begin
            push(S_WIN, 3);
        end else begin
            push(S_PHOLD, HOLD);
            push(S_AIROLL, SETTLE);
            push(S_AIAPPLY, 1);
            push(S_AICHECK, 1);
            pred_pl = (pred_pl > dpl) ? pred_pl - dpl : 0;
            if (pred_pl == 0) begin
                push(S_LOSE, 3);
            end else begin
                push(S_AIHOLD, HOLD);
                push(S_WAIT, 2);
                if (exp_turn < TMAX) exp_turn++;
            end
        end
        p_move_in = pm;
        exp_pm    = int'(pm);
        go_rel    = int'($urandom_range(1, 60));
        go        = 1'b1;
        check_trace("round");
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        go        = 1'b0;
        p_move_in = 2'b00;

        // Reset state.
        repeat (2) tick();
        chk("reset_outs", obs_vec(), exp_vec(S_IDLE));
        chk("reset_turn", 32'(turn_cnt), 32'd0);
        chk("reset_pmove", 32'(p_move), 32'd0);
        rst = 1'b1;
        tick();
        chk("idle_outs", obs_vec(), exp_vec(S_IDLE));

        // Start from IDLE with start held; a held level must not retrigger.
        do_start(S_IDLE);

        // A fresh start press in WAIT_MOVE is ignored.
        start = 1'b1;
        go_rel = 0;
        push(S_WAIT, 3);
        check_trace("start_in_wait");

        // First round with move 2'b10, nobody dies.
        do_round(2'b10, 5, 7);

        // Reset during P_ROLL.
        p_move_in = 2'b01;
        go = 1'b1;
        repeat (4) tick();
        chk("mid_roll", obs_vec(), exp_vec(S_PROLL));
        rst = 1'b0;
        go  = 1'b0;
        tick();
        chk("reset_mid_outs", obs_vec(), exp_vec(S_IDLE));
        chk("reset_mid_turn", 32'(turn_cnt), 32'd0);
        chk("reset_mid_pmove", 32'(p_move), 32'd0);
        rst = 1'b1;
        exp_turn = 0;
        exp_pm   = 0;
        tick();
        chk("post_reset_idle", obs_vec(), exp_vec(S_IDLE));

        // Player lands a killing blow: P_CHECK then WIN, no player damage strobe.
        do_start(S_IDLE);
        do_round(2'($urandom), 255, 255);
        chk("win_flag", 32'(win), 32'd1);
        chk("ai_hp_zero", 32'(ai_hp), 32'd0);
        chk("pl_hp_untouched", 32'(pl_hp), 32'(pl_init));

        // Restart from WIN, then 64 surviving rounds to saturate the turn counter.
        ai_init = 8'd250;
        pl_init = 8'd250;
        do_start(S_WIN);
        for (int r = 0; r < 64; r++) begin
            do_round(2'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        chk("turn_saturated", 32'(turn_cnt), 32'(TMAX));
        chk("ai_hp_track", 32'(ai_hp), 32'(pred_ai));
        chk("pl_hp_track", 32'(pl_hp), 32'(pred_pl));

        // AI kills the player: LOSE, then a start press goes back through LOAD.
        do_round(2'($urandom), 1, 255);
        chk("lose_flag", 32'(lose), 32'd1);
        chk("lose_turn_kept", 32'(turn_cnt), 32'(TMAX));
        do_start(S_LOSE);
        chk("lose_cleared", 32'(lose), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pbs_turn_ctrl.md
Name: pbs_turn_ctrl

Overview:
- Turn sequencer for the battle datapath.
- Drives the datapath's trainer select (actr), RNG freeze (stop), damage-apply strobes and AI-HP load.
- Orders each battle round as: player move select → RNG roll → player attack → death check → AI roll → AI attack → death check.
- Reports turn count and win/lose status to the display/top level.

Parameters:
- SETTLE_CYCLES, 8, cycles the RNGs free-run (stop=0) before each attack; legal range 1..255.
- HOLD_CYCLES, 16, cycles the result is held after each attack before the next phase; legal range 1..255.
- TURN_W, 6, width of the turn counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  begin/restart battle (synchronous, debounced level).
- go  input  1  confirm player move (synchronous, debounced level).
- p_move_in  input  2  player move selection.
- ai_dead  input  1  AI HP is zero (combinational from datapath HP).
- p_dead  input  1  player HP is zero.
- actr  output  1  0 = player is attacker, 1 = AI is attacker.
- stop  output  1  1 = RNGs frozen.
- app_ai_dmg  output  1  one-cycle strobe: apply damage to AI.
- app_pl_dmg  output  1  one-cycle strobe: apply damage to player.
- load_ai_hp  output  1  one-cycle strobe at battle start.
- p_move  output  2  move latched on go press.
- turn_cnt  output  TURN_W  completed full rounds; saturating.
- win  output  1  battle won (AI dead).
- lose  output  1  battle lost (player dead).
- busy  output  1  high in every state except IDLE, WAIT_MOVE, WIN, LOSE.
- state_dbg  output  4  current state encoding.

Behaviour:
- Reset: rst=0 at any posedge → state IDLE, all counters 0, p_move=0, actr=0, stop=1, all strobes 0, win=lose=busy=0. Applies mid-operation; strobes drop in the same cycle.
- Edge detect: press_go = go & ~go_q and press_start = start & ~start_q, where go_q/start_q are registered copies. Holding a level produces only one event.
- States and transitions:
  - IDLE: on press_start → LOAD.
  - LOAD: load_ai_hp=1 for exactly 1 cycle; turn_cnt cleared; next state WAIT_MOVE.
  - WAIT_MOVE: on press_go, latch p_move_in → p_move, then → P_ROLL. press_start is ignored here.
  - P_ROLL: actr=0, stop=0 for exactly SETTLE_CYCLES cycles, then → P_APPLY.
  - P_APPLY: actr=0, stop=1, app_ai_dmg=1 for exactly 1 cycle; → P_CHECK.
  - P_CHECK: 1 cycle, during which the datapath's dead flags reflect the updated HP. If ai_dead → WIN, else → P_HOLD.
  - P_HOLD: HOLD_CYCLES cycles; → AI_ROLL.
  - AI_ROLL: actr=1, stop=0 for SETTLE_CYCLES cycles; → AI_APPLY.
  - AI_APPLY: actr=1, stop=1, app_pl_dmg=1 for 1 cycle; → AI_CHECK.
  - AI_CHECK: if p_dead → LOSE, else → AI_HOLD.
  - AI_HOLD: HOLD_CYCLES cycles; turn_cnt += 1 (saturating at all-ones) on exit; → WAIT_MOVE.
  - WIN/LOSE: win or lose held high; on press_start → LOAD.
- Outputs outside those listed: stop=1, app_ai_dmg=0, app_pl_dmg=0. actr=1 only in AI_ROLL and AI_APPLY, 0 elsewhere.
- All control outputs are registered (Moore) and change on the clock edge of the state entry.
- app_ai_dmg and app_pl_dmg are never high in the same cycle.
- Timing: app_ai_dmg rises SETTLE_CYCLES+1 cycles after the edge where press_go is sampled.
- Both dead flags high in a check state: only the flag checked in that state matters. ai_dead takes priority in P_CHECK; p_dead is ignored there.
- Counter: a single 8-bit phase counter, cleared on every state entry. It compares against SETTLE_CYCLES-1 / HOLD_CYCLES-1.

Decomposition:
- pbs_pkg holds:
  - state enum with fixed 4-bit codes: IDLE=0, LOAD=1, WAIT_MOVE=2, P_ROLL=3, P_APPLY=4, P_CHECK=5, P_HOLD=6, AI_ROLL=7, AI_APPLY=8, AI_CHECK=9, AI_HOLD=10, WIN=11, LOSE=12.
  - the actr encodings (PLAYER=0, AI=1).
- Sub-module pbs_edge_det: one-bit rising-edge detector, instantiated twice (go, start).

Test Plan:
- Reset in P_ROLL (rst=0 one cycle) → next cycle state_dbg=0, stop=1, all strobes 0, turn_cnt=0.
- press_start from IDLE → load_ai_hp high exactly 1 cycle, then state_dbg=2. A held start does not retrigger.
- SETTLE_CYCLES=8, go press with p_move_in=2'b10 → p_move=2 latched; stop=0 for exactly 8 cycles with actr=0; app_ai_dmg high exactly 1 cycle at press+9 cycles.
- Datapath model with ai_dead forced 1 after app_ai_dmg → state goes P_CHECK then WIN; win=1; app_pl_dmg never asserted.
- Full round with neither side dead → actr=1 for 8+1 cycles, one app_pl_dmg pulse, HOLD of 16 cycles, turn_cnt 0→1, state_dbg=2. Repeat 64 rounds with TURN_W=6 → turn_cnt saturates at 63.
- p_dead=1 in AI_CHECK → LOSE with lose=1. press_start → LOAD, lose cleared, turn_cnt=0.
